// File: rtl/cache_ctrl_assoc.sv
// N-way set-associative, write-back, write-allocate cache controller with LRU
// replacement, a registered one-cycle response strobe and saturating hit/miss counters.
module cache_ctrl_assoc #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 128,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned SETS   = 256,
    parameter int unsigned WAYS   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [WORD_W-1:0] cpu_req_datain,
    input  logic              cpu_req_rw,
    input  logic              cpu_req_valid,
    output logic              cache_ready,
    output logic              cpu_resp_valid,
    output logic [WORD_W-1:0] cpu_req_dataout,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic [LINE_W-1:0] mem_req_datain,
    output logic [LINE_W-1:0] mem_req_dataout,
    output logic              mem_req_rw,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int unsigned OFF    = $clog2(LINE_W / 8);
    localparam int unsigned IDX    = $clog2(SETS);
    localparam int unsigned TAG_W  = ADDR_W - OFF - IDX;
    localparam int unsigned WB     = $clog2(WORD_W / 8);
    localparam int unsigned WORDS  = LINE_W / WORD_W;
    localparam int unsigned WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {StIdle, StCompare, StWriteback, StAllocate} state_e;

    state_e state_q, state_d;
    logic [ADDR_W-1:0] req_addr_q;
    logic [WORD_W-1:0] req_data_q;
    logic              req_rw_q;
    logic              filled_q, filled_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic              mem_valid_q, mem_valid_d, mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_dout_q, mem_dout_d;
    logic              resp_valid_q, resp_valid_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic [31:0]       hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    // Storage: tags/data are plain RAM, per-way metadata is reset.
    logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
    logic [LINE_W-1:0] data_mem [SETS][WAYS];
    logic              valid_q  [SETS][WAYS];
    logic              dirty_q  [SETS][WAYS];
    logic [WAY_W-1:0]  age_q    [SETS][WAYS];

    logic [TAG_W-1:0]  req_tag;
    logic [IDX-1:0]    req_idx;
    logic [WSEL_W-1:0] word_sel;
    logic              hit, found_inv, accept, do_hit, do_wb_done, do_fill;
    logic [WAY_W-1:0]  hit_way, victim, max_age;
    logic [WORD_W-1:0] hit_word;
    logic              unused_addr;

    assign req_tag     = req_addr_q[ADDR_W-1 -: TAG_W];
    assign req_idx     = req_addr_q[OFF +: IDX];
    assign word_sel    = WSEL_W'(req_addr_q[OFF-1:0] >> WB);
    assign hit_word    = data_mem[req_idx][hit_way][word_sel*WORD_W +: WORD_W];
    assign unused_addr = ^req_addr_q;

    assign cache_ready     = (state_q == StIdle);
    assign cpu_resp_valid  = resp_valid_q;
    assign cpu_req_dataout = dout_q;
    assign mem_req_valid   = mem_valid_q;
    assign mem_req_rw      = mem_rw_q;
    assign mem_req_addr    = mem_addr_q;
    assign mem_req_dataout = mem_dout_q;
    assign hit_count       = hit_cnt_q;
    assign miss_count      = miss_cnt_q;

    // Tag lookup and victim selection (lowest invalid way, else oldest way).
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        found_inv = 1'b0;
        victim    = '0;
        max_age   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[req_idx][w] && tag_mem[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!found_inv && !valid_q[req_idx][w]) begin
                found_inv = 1'b1;
                victim    = WAY_W'(w);
            end
        end
        if (!found_inv) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[req_idx][w] > max_age) begin
                    max_age = age_q[req_idx][w];
                    victim  = WAY_W'(w);
                end
            end
        end
    end

    // Next-state logic and next values of the registered outputs.
    always_comb begin
        state_d      = state_q;
        filled_d     = filled_q;
        victim_d     = victim_q;
        mem_valid_d  = mem_valid_q;
        mem_rw_d     = mem_rw_q;
        mem_addr_d   = mem_addr_q;
        mem_dout_d   = mem_dout_q;
        resp_valid_d = 1'b0;
        dout_d       = dout_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        accept       = 1'b0;
        do_hit       = 1'b0;
        do_wb_done   = 1'b0;
        do_fill      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cpu_req_valid) begin
                    accept   = 1'b1;
                    filled_d = 1'b0;
                    state_d  = StCompare;
                end
            end
            StCompare: begin
                if (hit) begin
                    do_hit       = 1'b1;
                    resp_valid_d = 1'b1;
                    dout_d       = req_rw_q ? req_data_q : hit_word;
                    // The re-compare after a fill belongs to a request already counted as a miss.
                    if (!filled_q && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
                    state_d = StIdle;
                end else begin
                    if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
                    victim_d    = victim;
                    mem_valid_d = 1'b1;
                    if (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) begin
                        mem_rw_d   = 1'b1;
                        mem_addr_d = {tag_mem[req_idx][victim], req_idx, {OFF{1'b0}}};
                        mem_dout_d = data_mem[req_idx][victim];
                        state_d    = StWriteback;
                    end else begin
                        mem_rw_d   = 1'b0;
                        mem_addr_d = {req_tag, req_idx, {OFF{1'b0}}};
                        state_d    = StAllocate;
                    end
                end
            end
            StWriteback: begin
                if (mem_req_ready) begin
                    do_wb_done = 1'b1;
                    mem_rw_d   = 1'b0;
                    mem_addr_d = {req_tag, req_idx, {OFF{1'b0}}};
                    state_d    = StAllocate;
                end
            end
            StAllocate: begin
                if (mem_req_ready) begin
                    do_fill     = 1'b1;
                    filled_d    = 1'b1;
                    mem_valid_d = 1'b0;
                    state_d     = StCompare;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state, request latch, registered outputs and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            req_addr_q   <= '0;
            req_data_q   <= '0;
            req_rw_q     <= 1'b0;
            filled_q     <= 1'b0;
            victim_q     <= '0;
            mem_valid_q  <= 1'b0;
            mem_rw_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_dout_q   <= '0;
            resp_valid_q <= 1'b0;
            dout_q       <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            filled_q     <= filled_d;
            victim_q     <= victim_d;
            mem_valid_q  <= mem_valid_d;
            mem_rw_q     <= mem_rw_d;
            mem_addr_q   <= mem_addr_d;
            mem_dout_q   <= mem_dout_d;
            resp_valid_q <= resp_valid_d;
            dout_q       <= dout_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            if (accept) begin
                req_addr_q <= cpu_req_addr;
                req_data_q <= cpu_req_datain;
                req_rw_q   <= cpu_req_rw;
            end
        end
    end

    // Valid/dirty/age metadata. A filled way is first moved to the oldest slot so the
    // following hit promotes it; this rebuilds a proper age permutation after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= '0;
                end
            end
        end else begin
            if (do_hit) begin
                if (req_rw_q) dirty_q[req_idx][hit_way] <= 1'b1;
                if (WAYS > 1) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (WAY_W'(w) == hit_way) begin
                            age_q[req_idx][w] <= '0;
                        end else if (age_q[req_idx][w] < age_q[req_idx][hit_way]) begin
                            age_q[req_idx][w] <= age_q[req_idx][w] + 1'b1;
                        end
                    end
                end
            end
            if (do_wb_done) dirty_q[req_idx][victim_q] <= 1'b0;
            if (do_fill) begin
                valid_q[req_idx][victim_q] <= 1'b1;
                dirty_q[req_idx][victim_q] <= 1'b0;
                if (WAYS > 1) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (WAY_W'(w) == victim_q) begin
                            age_q[req_idx][w] <= WAY_W'(WAYS - 1);
                        end else if (age_q[req_idx][w] > age_q[req_idx][victim_q]) begin
                            age_q[req_idx][w] <= age_q[req_idx][w] - 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Tag and data RAM writes: word update on write hit, whole line on fill.
    always_ff @(posedge clk) begin
        if (do_hit && req_rw_q) begin
            data_mem[req_idx][hit_way][word_sel*WORD_W +: WORD_W] <= req_data_q;
        end
        if (do_fill) begin
            data_mem[req_idx][victim_q] <= mem_req_datain;
            tag_mem[req_idx][victim_q]  <= req_tag;
        end
    end

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Scoreboard bench for cache_ctrl_assoc: a timestamp-LRU reference model predicts CPU
// responses and memory transactions; monitors pop and compare as the DUT presents them.
module tb_cache_ctrl_assoc;

    localparam int SETS = 256;
    localparam int WAYS = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  cpu_req_addr, cpu_req_datain, cpu_req_dataout;
    logic         cpu_req_rw, cpu_req_valid, cache_ready, cpu_resp_valid;
    logic [31:0]  mem_req_addr, hit_count, miss_count;
    logic [127:0] mem_req_datain, mem_req_dataout;
    logic         mem_req_rw, mem_req_valid, mem_req_ready;
    bit           hold_ready;
    int           n_vec, n_fail;

    typedef struct packed {logic rw; logic [31:0] data;} resp_t;
    typedef struct packed {logic rw; logic [31:0] addr; logic [127:0] line;} memtx_t;

    resp_t        exp_resp[$];
    memtx_t       exp_mem[$];
    logic [127:0] ref_mem [int unsigned];
    logic [127:0] act_mem [int unsigned];

    // Reference cache: per-way contents plus a last-use timestamp for LRU.
    bit              m_v   [SETS][WAYS];
    bit              m_d   [SETS][WAYS];
    int unsigned     m_tag [SETS][WAYS];
    logic [127:0]    m_line[SETS][WAYS];
    longint unsigned m_use [SETS][WAYS];
    longint unsigned m_now;
    logic [31:0]     m_hits, m_misses;

    always #5 clk = ~clk;

    cache_ctrl_assoc dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_datain (cpu_req_datain),
        .cpu_req_rw     (cpu_req_rw),
        .cpu_req_valid  (cpu_req_valid),
        .cache_ready    (cache_ready),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_req_dataout(cpu_req_dataout),
        .mem_req_addr   (mem_req_addr),
        .mem_req_datain (mem_req_datain),
        .mem_req_dataout(mem_req_dataout),
        .mem_req_rw     (mem_req_rw),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready)  ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    function automatic logic [127:0] init_line(input logic [31:0] a);
        return {a ^ 32'h5A5A_0003, a ^ 32'h5A5A_0002, a ^ 32'h5A5A_0001, a ^ 32'h5A5A_0000};
    endfunction

    function automatic logic [127:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_line(a);
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected expected event", name);
    endtask

    // Apply one CPU request to the model; queue the expected traffic; return hit/miss.
    function automatic bit model_access(input logic [31:0] addr, input logic rw,
                                        input logic [31:0] data);
        int unsigned idx, tag, wsel;
        int          w_hit, vic;
        bit          was_hit;
        memtx_t      t;
        resp_t       r;
        logic [31:0] la;
        idx   = addr[11:4];
        tag   = addr[31:12];
        wsel  = addr[3:2];
        w_hit = -1;
        vic   = -1;
        for (int w = 0; w < WAYS; w++) if (m_v[idx][w] && m_tag[idx][w] == tag) w_hit = w;
        was_hit = (w_hit >= 0);
        if (!was_hit) begin
            if (m_misses != 32'hFFFF_FFFF) m_misses++;
            for (int w = WAYS - 1; w >= 0; w--) if (!m_v[idx][w]) vic = w;
            if (vic < 0) begin
                vic = 0;
                for (int w = 1; w < WAYS; w++) if (m_use[idx][w] < m_use[idx][vic]) vic = w;
            end
            if (m_v[idx][vic] && m_d[idx][vic]) begin
                t.rw   = 1'b1;
                t.addr = (m_tag[idx][vic] << 12) | (idx << 4);
                t.line = m_line[idx][vic];
                exp_mem.push_back(t);
            end
            la     = {addr[31:4], 4'h0};
            t.rw   = 1'b0;
            t.addr = la;
            t.line = '0;
            exp_mem.push_back(t);
            m_line[idx][vic] = ref_read(la);
            m_v[idx][vic]    = 1'b1;
            m_d[idx][vic]    = 1'b0;
            m_tag[idx][vic]  = tag;
            w_hit            = vic;
        end else if (m_hits != 32'hFFFF_FFFF) begin
            m_hits++;
        end
        m_now++;
        m_use[idx][w_hit] = m_now;
        r.rw = rw;
        if (rw) begin
            m_line[idx][w_hit][wsel*32 +: 32] = data;
            m_d[idx][w_hit] = 1'b1;
            r.data = data;
        end else begin
            r.data = m_line[idx][w_hit][wsel*32 +: 32];
        end
        exp_resp.push_back(r);
        return was_hit;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        exp_resp.delete();
        exp_mem.delete();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_v[s][w]   = 1'b0;
                m_d[s][w]   = 1'b0;
                m_use[s][w] = 0;
            end
        end
        m_hits   = '0;
        m_misses = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [31:0] a, input logic rw, input logic [31:0] d,
                        output bit hit);
        int n = 0;
        while (!cache_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!cache_ready) fail_now("ready_timeout");
        cpu_req_addr   = a;
        cpu_req_rw     = rw;
        cpu_req_datain = d;
        cpu_req_valid  = 1'b1;
        hit = model_access(a, rw, d);
        @(negedge clk);
        cpu_req_valid = 1'b0;
        check("ready_drop", cache_ready, 1'b0);
    endtask

    task automatic finish_req(input bit hit);
        int n = 0;
        @(negedge clk);
        if (hit) check("hit_latency", cpu_resp_valid, 1'b1);
        while (!cache_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!cache_ready) fail_now("done_timeout");
        check("hit_count", hit_count, m_hits);
        check("miss_count", miss_count, m_misses);
    endtask

    task automatic access(input logic [31:0] a, input logic rw, input logic [31:0] d);
        bit h;
        send(a, rw, d, h);
        finish_req(h);
    endtask

    // CPU response monitor.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (rst_n && cpu_resp_valid) begin
                if (exp_resp.size() == 0) begin
                    fail_now("unexpected_resp");
                end else begin
                    r = exp_resp.pop_front();
                    if (!r.rw) check("read_data", cpu_req_dataout, r.data);
                end
            end
        end
    end

    // Memory model and memory transaction monitor (acts just after the falling edge).
    initial begin
        memtx_t t;
        mem_req_ready  = 1'b0;
        mem_req_datain = '0;
        forever begin
            @(negedge clk);
            #1;
            mem_req_ready = !hold_ready;
            if (rst_n) begin
                mem_req_datain = act_mem.exists(mem_req_addr) ? act_mem[mem_req_addr]
                                                              : init_line(mem_req_addr);
                if (mem_req_valid && mem_req_ready) begin
                    if (exp_mem.size() == 0) begin
                        fail_now("unexpected_mem_req");
                    end else begin
                        t = exp_mem.pop_front();
                        check("mem_rw", mem_req_rw, t.rw);
                        check("mem_addr", mem_req_addr, t.addr);
                        if (t.rw) begin
                            check("wb_line", mem_req_dataout, t.line);
                            ref_mem[t.addr] = t.line;
                        end
                    end
                    if (mem_req_rw) act_mem[mem_req_addr] = mem_req_dataout;
                end
            end
        end
    end

    initial begin
        bit          h;
        int          n;
        logic [31:0] a;
        logic [7:0]  sets [3];
        n_vec          = 0;
        n_fail         = 0;
        hold_ready     = 1'b0;
        cpu_req_valid  = 1'b0;
        cpu_req_rw     = 1'b0;
        cpu_req_addr   = '0;
        cpu_req_datain = '0;
        m_now          = 0;
        sets[0] = 8'hB0;
        sets[1] = 8'h03;
        sets[2] = 8'h44;
        do_reset();

        check("rst_ready", cache_ready, 1'b1);
        check("rst_resp_valid", cpu_resp_valid, 1'b0);
        check("rst_dataout", cpu_req_dataout, 32'h0);
        check("rst_mem_valid", mem_req_valid, 1'b0);
        check("rst_hit_count", hit_count, 32'h0);
        check("rst_miss_count", miss_count, 32'h0);

        // Cold write then read-back hit.
        access(32'h0000_AB00, 1'b1, 32'h1122);
        check("t1_miss_count", miss_count, 32'd1);
        access(32'h0000_AB00, 1'b0, 32'h0);
        check("t1_hit_count", hit_count, 32'd1);

        // Two ways in one set, then re-read both.
        do_reset();
        access(32'h0001_AB00, 1'b0, 32'h0);
        access(32'h0002_AB00, 1'b0, 32'h0);
        access(32'h0001_AB00, 1'b0, 32'h0);
        access(32'h0002_AB00, 1'b0, 32'h0);
        check("t2_hit_count", hit_count, 32'd2);

        // LRU victim choice with clean and dirty victims.
        do_reset();
        access(32'h0000_AB04, 1'b1, 32'h55);
        access(32'h0001_AB00, 1'b0, 32'h0);
        access(32'h0000_AB00, 1'b0, 32'h0);
        access(32'h0002_AB00, 1'b0, 32'h0);
        access(32'h0003_AB00, 1'b0, 32'h0);
        check("t3_miss_count", miss_count, 32'd4);
        check("t3_wb_applied", act_mem.exists(32'h0000_AB00) ? act_mem[32'h0000_AB00][63:32]
                                                             : 32'h0, 32'h55);

        // Memory stall during a fill: outputs stable, new requests ignored.
        hold_ready = 1'b1;
        send(32'h0000_5C30, 1'b0, 32'h0, h);
        n = 0;
        while (!mem_req_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall_valid_seen", mem_req_valid, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cpu_req_addr  = 32'h0000_7700 + 32'(i);
            cpu_req_rw    = 1'b0;
            cpu_req_valid = 1'b1;
            @(negedge clk);
            check("stall_valid", mem_req_valid, 1'b1);
            check("stall_addr", mem_req_addr, 32'h0000_5C30);
            check("stall_rw", mem_req_rw, 1'b0);
            check("stall_ready", cache_ready, 1'b0);
        end
        cpu_req_valid = 1'b0;
        hold_ready    = 1'b0;
        finish_req(h);

        // Reset in the middle of a write-back.
        access(32'h0000_0100, 1'b1, 32'hCAFE);
        access(32'h0000_1100, 1'b0, 32'h0);
        hold_ready = 1'b1;
        send(32'h0000_2100, 1'b0, 32'h0, h);
        n = 0;
        while (!(mem_req_valid && mem_req_rw) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_wb_seen", mem_req_valid && mem_req_rw, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_mem_valid", mem_req_valid, 1'b0);
        hold_ready = 1'b0;
        do_reset();
        check("t5_ready", cache_ready, 1'b1);
        access(32'h0000_0100, 1'b0, 32'h0);
        check("t5_miss_after_rst", miss_count, 32'd1);

        // Randomized traffic over a few conflicting sets.
        for (int i = 0; i < 200; i++) begin
            a = ($urandom_range(0, 5) << 12) | (32'(sets[$urandom_range(0, 2)]) << 4)
              | $urandom_range(0, 15);
            access(a, 1'($urandom_range(0, 1)), $urandom);
        end

        // Miss counter saturation.
        force dut.miss_cnt_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.miss_cnt_q;
        m_misses = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) access(32'h0007_7200 + 32'(i << 4), 1'b0, 32'h0);
        check("miss_saturate", miss_count, 32'hFFFF_FFFF);

        repeat (3) @(negedge clk);
        check("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
        check("mem_queue_empty", 32'(exp_mem.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
